// File: rtl/vending_pkg.sv
// vending_pkg: shared state, error-code and selection constants for the vending controller
package vending_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PRICE = 2'd1;
  localparam logic [1:0] ERR_SOLDOUT = 2'd2;
  localparam logic [1:0] ERR_CODE = 2'd3;
  localparam int SEL_CANCEL = 0;
endpackage

// File: rtl/vending_if.sv
// vending_if: coin, keypad, restock and actuator handshake signals of the vending controller
interface vending_if #(
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 3,
  parameter int CREDIT_W = 4,
  parameter int STOCK_W = 3
);
  logic coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic sel_valid;
  logic [SEL_W-1:0] sel;
  logic restock_valid;
  logic [SEL_W-1:0] restock_item;
  logic [STOCK_W-1:0] restock_qty;
  logic dispense_valid;
  logic [SEL_W-1:0] dispense_item;
  logic dispense_ready;
  logic change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic change_ready;
  logic [CREDIT_W-1:0] credit;
  logic [N_ITEMS-1:0] avail_mask;
  logic coin_reject;
  logic err_valid;
  logic [1:0] err_code;
  modport slave(
    input coin_valid, coin_value, sel_valid, sel, restock_valid, restock_item, restock_qty,
    input dispense_ready, change_ready,
    output dispense_valid, dispense_item, change_valid, change_amount, credit, avail_mask,
    output coin_reject, err_valid, err_code
  );
  modport master(
    output coin_valid, coin_value, sel_valid, sel, restock_valid, restock_item, restock_qty,
    output dispense_ready, change_ready,
    input dispense_valid, dispense_item, change_valid, change_amount, credit, avail_mask,
    input coin_reject, err_valid, err_code
  );
endinterface

// File: rtl/vending_stock.sv
// vending_stock: per-item saturating stock counters with purchase decrement and restock add
module vending_stock
  import vending_pkg::*;
#(
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 3,
  parameter int STOCK_W = 3,
  parameter logic [N_ITEMS*STOCK_W-1:0] INIT_STOCK = {3'd2, 3'd2, 3'd1, 3'd2}
) (
  input  logic clk,
  input  logic rst,
  input  logic dec_valid_i,
  input  logic [SEL_W-1:0] dec_item_i,
  input  logic restock_valid_i,
  input  logic [SEL_W-1:0] restock_item_i,
  input  logic [STOCK_W-1:0] restock_qty_i,
  output logic [N_ITEMS-1:0] nonzero_o
);
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];
  function automatic logic [STOCK_W-1:0] next_stock(
    input logic [STOCK_W-1:0] s,
    input logic dec,
    input logic [STOCK_W-1:0] add
  );
    logic [STOCK_W:0] sum;
    sum = {1'b0, s} + {1'b0, add} - {{STOCK_W{1'b0}}, dec};
    return sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
  endfunction
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_d[i] = next_stock(stock_q[i], dec_valid_i && dec_item_i == SEL_W'(i + 1),
                              (restock_valid_i && restock_item_i == SEL_W'(i + 1)) ? restock_qty_i : '0);
      nonzero_o[i] = |stock_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INIT_STOCK[i*STOCK_W +: STOCK_W];
    else for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
  end
endmodule

// File: rtl/vending_controller.sv
// vending_controller: multi-item vending FSM with credit accumulation, stock, timeout and dispense/change handshakes
module vending_controller
  import vending_pkg::*;
#(
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 3,
  parameter int CREDIT_W = 4,
  parameter int STOCK_W = 3,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter logic [N_ITEMS*STOCK_W-1:0] INIT_STOCK = {3'd2, 3'd2, 3'd1, 3'd2},
  parameter int TIMEOUT_CYC = 1000
) (
  input logic clk,
  input logic rst,
  vending_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic disp_valid_q, disp_valid_d;
  logic [SEL_W-1:0] disp_item_q, disp_item_d;
  logic chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic coin_rej_q, coin_rej_d;
  logic err_valid_q, err_valid_d;
  logic [1:0] err_code_q, err_code_d;
  logic [N_ITEMS-1:0] in_stock, avail;
  logic [CREDIT_W-1:0] price;
  logic sel_in_stock, coin_ok, sel_take, is_cancel;
  logic [CREDIT_W:0] coin_sum;
  logic [1:0] sel_err;
  vending_stock #(
    .N_ITEMS(N_ITEMS), .SEL_W(SEL_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk(clk),
    .rst(rst),
    .dec_valid_i(sel_take),
    .dec_item_i(bus.sel),
    .restock_valid_i(bus.restock_valid),
    .restock_item_i(bus.restock_item),
    .restock_qty_i(bus.restock_qty),
    .nonzero_o(in_stock)
  );
  always_comb begin
    price = '0;
    sel_in_stock = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      avail[i] = in_stock[i] && PRICES[i*CREDIT_W +: CREDIT_W] <= credit_q;
      if (bus.sel == SEL_W'(i + 1)) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_in_stock = in_stock[i];
      end
    end
  end
  assign is_cancel = bus.sel == SEL_W'(SEL_CANCEL);
  assign sel_err = bus.sel > SEL_W'(N_ITEMS) ? ERR_CODE :
                   !sel_in_stock ? ERR_SOLDOUT :
                   price > credit_q ? ERR_PRICE : ERR_NONE;
  assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_ok = bus.coin_valid && !coin_sum[CREDIT_W] &&
                   (state_q == IDLE || (state_q == CREDIT && !bus.sel_valid));
  assign sel_take = state_q == CREDIT && bus.sel_valid && !is_cancel && sel_err == ERR_NONE;
  always_comb begin
    state_d = state_q;
    credit_d = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    timer_d = '0;
    disp_valid_d = disp_valid_q;
    disp_item_d = disp_item_q;
    chg_valid_d = chg_valid_q;
    chg_amt_d = chg_amt_q;
    coin_rej_d = bus.coin_valid && !coin_ok;
    err_valid_d = 1'b0;
    err_code_d = ERR_NONE;
    case (state_q)
      IDLE: state_d = coin_ok ? CREDIT : IDLE;
      CREDIT:
        if (bus.sel_valid && is_cancel) begin
          state_d = credit_q != '0 ? CHANGE : IDLE;
          chg_valid_d = credit_q != '0;
          chg_amt_d = credit_q;
        end else if (bus.sel_valid && sel_err != ERR_NONE) begin
          err_valid_d = 1'b1;
          err_code_d = sel_err;
        end else if (bus.sel_valid) begin
          credit_d = credit_q - price;
          disp_valid_d = 1'b1;
          disp_item_d = bus.sel;
          state_d = VEND;
        end else if (!bus.coin_valid && timer_q == T_LAST) begin
          state_d = CHANGE;
          chg_valid_d = 1'b1;
          chg_amt_d = credit_q;
        end else if (!bus.coin_valid) begin
          timer_d = timer_q + 1'b1;
        end
      VEND:
        if (bus.dispense_ready) begin
          disp_valid_d = 1'b0;
          state_d = credit_q != '0 ? CREDIT : IDLE;
        end
      CHANGE:
        if (bus.change_ready) begin
          chg_valid_d = 1'b0;
          credit_d = '0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      timer_q <= '0;
      disp_valid_q <= 1'b0;
      disp_item_q <= '0;
      chg_valid_q <= 1'b0;
      chg_amt_q <= '0;
      coin_rej_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      timer_q <= timer_d;
      disp_valid_q <= disp_valid_d;
      disp_item_q <= disp_item_d;
      chg_valid_q <= chg_valid_d;
      chg_amt_q <= chg_amt_d;
      coin_rej_q <= coin_rej_d;
      err_valid_q <= err_valid_d;
      err_code_q <= err_code_d;
    end
  end
  assign bus.dispense_valid = disp_valid_q;
  assign bus.dispense_item = disp_item_q;
  assign bus.change_valid = chg_valid_q;
  assign bus.change_amount = chg_amt_q;
  assign bus.credit = credit_q;
  assign bus.avail_mask = avail;
  assign bus.coin_reject = coin_rej_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed self-checking bench for vending_controller
module tb_vending_controller;
  import vending_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [2:0] exp_stock [4];
  vending_if bus();
  vending_controller dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
    tick();
    bus.coin_valid = 1'b0;
  endtask
  task automatic select(input logic [2:0] s);
    bus.sel_valid = 1'b1;
    bus.sel = s;
    tick();
    bus.sel_valid = 1'b0;
  endtask
  task automatic restock(input logic [2:0] item, input logic [2:0] qty);
    bus.restock_valid = 1'b1;
    bus.restock_item = item;
    bus.restock_qty = qty;
    tick();
    bus.restock_valid = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_stock = '{3'd2, 3'd1, 3'd2, 3'd2};
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, IDLE); end
    total++; if (bus.credit !== 4'd0) begin bad++; $display("FAIL rst_credit got=%0d exp=0", bus.credit); end
    total++; if (bus.dispense_valid !== 1'b0 || bus.change_valid !== 1'b0) begin bad++; $display("FAIL rst_valids got=%b%b exp=00", bus.dispense_valid, bus.change_valid); end
    total++; if (bus.avail_mask !== 4'b0000) begin bad++; $display("FAIL rst_avail got=%b exp=0000", bus.avail_mask); end
    total++; if (bus.coin_reject !== 1'b0 || bus.err_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", bus.coin_reject, bus.err_valid); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dut.u_stock.stock_q[i] !== exp_stock[i]) begin bad++; $display("FAIL rst_stock%0d got=%0d exp=%0d", i + 1, dut.u_stock.stock_q[i], exp_stock[i]); end
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_purchase();
    coin(4'd2);
    total++; if (bus.credit !== 4'd2 || dut.state_q !== CREDIT) begin bad++; $display("FAIL p_coin2 got credit=%0d state=%0d exp credit=2 state=1", bus.credit, dut.state_q); end
    total++; if (bus.avail_mask !== 4'b0011) begin bad++; $display("FAIL p_avail2 got=%b exp=0011", bus.avail_mask); end
    coin(4'd3);
    total++; if (bus.credit !== 4'd5) begin bad++; $display("FAIL p_coin5 got=%0d exp=5", bus.credit); end
    total++; if (bus.avail_mask !== 4'b1111) begin bad++; $display("FAIL p_avail5 got=%b exp=1111", bus.avail_mask); end
    select(3'd4);
    exp_stock[3] = 3'd1;
    total++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 3'd4) begin bad++; $display("FAIL p_disp got v=%b item=%0d exp v=1 item=4", bus.dispense_valid, bus.dispense_item); end
    total++; if (bus.credit !== 4'd1 || dut.state_q !== VEND) begin bad++; $display("FAIL p_after got credit=%0d state=%0d exp credit=1 state=2", bus.credit, dut.state_q); end
    total++; if (dut.u_stock.stock_q[3] !== exp_stock[3]) begin bad++; $display("FAIL p_stock4 got=%0d exp=%0d", dut.u_stock.stock_q[3], exp_stock[3]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 3'd4) begin bad++; $display("FAIL p_hold%0d got v=%b item=%0d exp v=1 item=4", i, bus.dispense_valid, bus.dispense_item); end
    end
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    total++; if (bus.dispense_valid !== 1'b0 || dut.state_q !== CREDIT) begin bad++; $display("FAIL p_done got v=%b state=%0d exp v=0 state=1", bus.dispense_valid, dut.state_q); end
    repeat (999) tick();
    total++; if (bus.change_valid !== 1'b0 || dut.state_q !== CREDIT) begin bad++; $display("FAIL p_pre_timeout got v=%b state=%0d exp v=0 state=1", bus.change_valid, dut.state_q); end
    tick();
    total++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 4'd1 || dut.state_q !== CHANGE) begin bad++; $display("FAIL p_timeout got v=%b amt=%0d state=%0d exp v=1 amt=1 state=3", bus.change_valid, bus.change_amount, dut.state_q); end
    bus.change_ready = 1'b1;
    tick();
    bus.change_ready = 1'b0;
    total++; if (dut.state_q !== IDLE || bus.credit !== 4'd0 || bus.change_valid !== 1'b0) begin bad++; $display("FAIL p_change_done got state=%0d credit=%0d v=%b exp 0 0 0", dut.state_q, bus.credit, bus.change_valid); end
  endtask
  task automatic test_overflow();
    coin(4'd8);
    coin(4'd7);
    total++; if (bus.credit !== 4'd15) begin bad++; $display("FAIL o_credit15 got=%0d exp=15", bus.credit); end
    coin(4'd1);
    total++; if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd15) begin bad++; $display("FAIL o_reject got rej=%b credit=%0d exp rej=1 credit=15", bus.coin_reject, bus.credit); end
    tick();
    total++; if (bus.coin_reject !== 1'b0) begin bad++; $display("FAIL o_pulse got=%b exp=0", bus.coin_reject); end
    select(3'd0);
    total++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 4'd15 || dut.state_q !== CHANGE) begin bad++; $display("FAIL o_cancel got v=%b amt=%0d state=%0d exp v=1 amt=15 state=3", bus.change_valid, bus.change_amount, dut.state_q); end
    tick();
    total++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 4'd15) begin bad++; $display("FAIL o_hold got v=%b amt=%0d exp v=1 amt=15", bus.change_valid, bus.change_amount); end
    bus.change_ready = 1'b1;
    tick();
    bus.change_ready = 1'b0;
    total++; if (dut.state_q !== IDLE || bus.credit !== 4'd0 || bus.change_valid !== 1'b0) begin bad++; $display("FAIL o_done got state=%0d credit=%0d v=%b exp 0 0 0", dut.state_q, bus.credit, bus.change_valid); end
  endtask
  task automatic test_soldout();
    coin(4'd2);
    select(3'd2);
    exp_stock[1] = 3'd0;
    total++; if (bus.dispense_item !== 3'd2 || bus.credit !== 4'd0 || dut.u_stock.stock_q[1] !== exp_stock[1]) begin bad++; $display("FAIL s_buy got item=%0d credit=%0d stock=%0d exp 2 0 0", bus.dispense_item, bus.credit, dut.u_stock.stock_q[1]); end
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    total++; if (dut.state_q !== IDLE || bus.dispense_valid !== 1'b0) begin bad++; $display("FAIL s_idle got state=%0d v=%b exp state=0 v=0", dut.state_q, bus.dispense_valid); end
    coin(4'd2);
    total++; if (bus.avail_mask !== 4'b0001) begin bad++; $display("FAIL s_avail got=%b exp=0001", bus.avail_mask); end
    select(3'd2);
    total++; if (bus.err_valid !== 1'b1 || bus.err_code !== ERR_SOLDOUT) begin bad++; $display("FAIL s_err got v=%b code=%0d exp v=1 code=2", bus.err_valid, bus.err_code); end
    total++; if (bus.credit !== 4'd2 || dut.state_q !== CREDIT) begin bad++; $display("FAIL s_keep got credit=%0d state=%0d exp credit=2 state=1", bus.credit, dut.state_q); end
    tick();
    total++; if (bus.err_valid !== 1'b0) begin bad++; $display("FAIL s_pulse got=%b exp=0", bus.err_valid); end
    restock(3'd2, 3'd7);
    exp_stock[1] = 3'd7;
    total++; if (dut.u_stock.stock_q[1] !== exp_stock[1]) begin bad++; $display("FAIL s_restock got=%0d exp=%0d", dut.u_stock.stock_q[1], exp_stock[1]); end
    restock(3'd2, 3'd7);
    total++; if (dut.u_stock.stock_q[1] !== 3'd7) begin bad++; $display("FAIL s_saturate got=%0d exp=7", dut.u_stock.stock_q[1]); end
    total++; if (bus.avail_mask !== 4'b0011) begin bad++; $display("FAIL s_avail2 got=%b exp=0011", bus.avail_mask); end
    restock(3'd0, 3'd3);
    restock(3'd5, 3'd3);
    for (int i = 0; i < 4; i++) begin
      total++; if (dut.u_stock.stock_q[i] !== exp_stock[i]) begin bad++; $display("FAIL s_ignore_stock%0d got=%0d exp=%0d", i + 1, dut.u_stock.stock_q[i], exp_stock[i]); end
    end
    select(3'd0);
    total++; if (bus.change_amount !== 4'd2 || bus.change_valid !== 1'b1) begin bad++; $display("FAIL s_cancel got v=%b amt=%0d exp v=1 amt=2", bus.change_valid, bus.change_amount); end
    bus.change_ready = 1'b1;
    tick();
    bus.change_ready = 1'b0;
  endtask
  task automatic test_errors();
    coin(4'd1);
    select(3'd3);
    total++; if (bus.err_valid !== 1'b1 || bus.err_code !== ERR_PRICE || bus.credit !== 4'd1) begin bad++; $display("FAIL e_price got v=%b code=%0d credit=%0d exp 1 1 1", bus.err_valid, bus.err_code, bus.credit); end
    repeat (500) tick();
    select(3'd6);
    total++; if (bus.err_valid !== 1'b1 || bus.err_code !== ERR_CODE || bus.credit !== 4'd1) begin bad++; $display("FAIL e_code got v=%b code=%0d credit=%0d exp 1 3 1", bus.err_valid, bus.err_code, bus.credit); end
    total++; if (dut.state_q !== CREDIT) begin bad++; $display("FAIL e_state got=%0d exp=1", dut.state_q); end
    repeat (999) tick();
    total++; if (bus.change_valid !== 1'b0) begin bad++; $display("FAIL e_restart got=%b exp=0", bus.change_valid); end
    tick();
    total++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 4'd1) begin bad++; $display("FAIL e_timeout got v=%b amt=%0d exp v=1 amt=1", bus.change_valid, bus.change_amount); end
    bus.change_ready = 1'b1;
    tick();
    bus.change_ready = 1'b0;
  endtask
  task automatic test_collision();
    coin(4'd1);
    bus.sel_valid = 1'b1;
    bus.sel = 3'd1;
    bus.restock_valid = 1'b1;
    bus.restock_item = 3'd1;
    bus.restock_qty = 3'd2;
    tick();
    bus.sel_valid = 1'b0;
    bus.restock_valid = 1'b0;
    exp_stock[0] = 3'd3;
    total++; if (bus.dispense_item !== 3'd1 || bus.credit !== 4'd0) begin bad++; $display("FAIL c_buy got item=%0d credit=%0d exp 1 0", bus.dispense_item, bus.credit); end
    total++; if (dut.u_stock.stock_q[0] !== exp_stock[0]) begin bad++; $display("FAIL c_stock got=%0d exp=%0d", dut.u_stock.stock_q[0], exp_stock[0]); end
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL c_idle got=%0d exp=0", dut.state_q); end
  endtask
  task automatic test_reset_in_vend();
    coin(4'd4);
    select(3'd3);
    exp_stock[2] = 3'd1;
    total++; if (dut.state_q !== VEND || bus.credit !== 4'd1 || dut.u_stock.stock_q[2] !== exp_stock[2]) begin bad++; $display("FAIL r_vend got state=%0d credit=%0d stock=%0d exp 2 1 1", dut.state_q, bus.credit, dut.u_stock.stock_q[2]); end
    coin(4'd1);
    total++; if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd1 || dut.state_q !== VEND) begin bad++; $display("FAIL r_vend_coin got rej=%b credit=%0d state=%0d exp 1 1 2", bus.coin_reject, bus.credit, dut.state_q); end
    #2 rst = 1'b1;
    #1;
    exp_stock = '{3'd2, 3'd1, 3'd2, 3'd2};
    total++; if (bus.dispense_valid !== 1'b0 || bus.credit !== 4'd0 || dut.state_q !== IDLE) begin bad++; $display("FAIL r_async got v=%b credit=%0d state=%0d exp 0 0 0", bus.dispense_valid, bus.credit, dut.state_q); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dut.u_stock.stock_q[i] !== exp_stock[i]) begin bad++; $display("FAIL r_stock%0d got=%0d exp=%0d", i + 1, dut.u_stock.stock_q[i], exp_stock[i]); end
    end
    tick();
    rst = 1'b0;
    tick();
    total++; if (dut.state_q !== IDLE || bus.dispense_valid !== 1'b0) begin bad++; $display("FAIL r_after got state=%0d v=%b exp 0 0", dut.state_q, bus.dispense_valid); end
  endtask
  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.sel_valid = 1'b0;
    bus.sel = '0;
    bus.restock_valid = 1'b0;
    bus.restock_item = '0;
    bus.restock_qty = '0;
    bus.dispense_ready = 1'b0;
    bus.change_ready = 1'b0;
    test_reset();
    test_purchase();
    test_overflow();
    test_soldout();
    test_errors();
    test_collision();
    test_reset_in_vend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
